// File: rtl/game_sequencer_if.sv
// Game-flow bus between the game environment and game_sequencer.
// Inputs come from the player, formation and bullet blocks and from the frame timer.
// Outputs gate and reload those blocks.
// Handshake: none. Every signal is sampled on each rising clk edge.
// Pulses (level_load_o, player_reset_o) are high for exactly one cycle.
interface game_sequencer_if;
    logic       tick_i;
    logic       shoot_i;
    logic       hit_i;
    logic       cleared_i;
    logic       landed_i;
    logic       run_o;
    logic       flash_o;
    logic       level_load_o;
    logic       player_reset_o;
    logic [1:0] lives_o;
    logic [7:0] level_o;
    logic [5:0] state_o;

    // Environment side: drives the events, observes the controls.
    modport master (
        output tick_i, shoot_i, hit_i, cleared_i, landed_i,
        input  run_o, flash_o, level_load_o, player_reset_o, lives_o, level_o, state_o
    );

    // Sequencer side.
    modport slave (
        input  tick_i, shoot_i, hit_i, cleared_i, landed_i,
        output run_o, flash_o, level_load_o, player_reset_o, lives_o, level_o, state_o
    );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE / PLAY / HIT_PAUSE / LEVEL_CLEAR / GAME_OVER / GAME_WON.
// It owns the lives and level counters and freezes the world (run_o=0) in pause and end states.
// Pause and end states accept a shoot edge only after hold_frames_p frame ticks.
// Optional macro GAME_SEQ_BONUS_LIFE_EN: entering an even level grants a spare life,
// up to max_lives_p.
module game_sequencer #(
    parameter int max_level_p   = 8,
    parameter int start_lives_p = 2,
    parameter int max_lives_p   = 3,
    parameter int hold_frames_p = 120
) (
    input  logic               clk_i,
    input  logic               reset_i,
    game_sequencer_if.slave    bus
);
    localparam int         HW          = $clog2(hold_frames_p + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(hold_frames_p);
    localparam logic [7:0] MAX_LEVEL   = 8'(max_level_p);
    localparam logic [1:0] MAX_LIVES   = 2'(max_lives_p);
    // The reload value never exceeds the ceiling.
    localparam logic [1:0] START_LIVES =
        (start_lives_p > max_lives_p) ? MAX_LIVES : 2'(start_lives_p);

    typedef enum logic [5:0] {
        IDLE        = 6'b000001,
        PLAY        = 6'b000010,
        HIT_PAUSE   = 6'b000100,
        LEVEL_CLEAR = 6'b001000,
        GAME_OVER   = 6'b010000,
        GAME_WON    = 6'b100000
    } state_t;

    state_t        state_q;
    logic [HW-1:0] hold_q;
    logic [2:0]    flash_cnt_q;
    logic          shoot_prev_q;
    logic          run_q, flash_q, level_load_q, player_reset_q;
    logic [1:0]    lives_q;
    logic [7:0]    level_q;

    logic          shoot_edge;
    logic          held;
    logic [7:0]    next_level;

    // Rising edge of the button, the hold-satisfied flag and the next level number.
    assign shoot_edge = bus.shoot_i & ~shoot_prev_q;
    assign held       = (hold_q == HOLD_MAX);
    assign next_level = level_q + 8'd1;

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            flash_cnt_q    <= '0;
            shoot_prev_q   <= 1'b0;
            run_q          <= 1'b0;
            flash_q        <= 1'b0;
            level_load_q   <= 1'b0;
            player_reset_q <= 1'b0;
            lives_q        <= START_LIVES;
            level_q        <= 8'd1;
        end else begin
            shoot_prev_q   <= bus.shoot_i;
            level_load_q   <= 1'b0;
            player_reset_q <= 1'b0;
            if (bus.tick_i && !held) hold_q <= hold_q + HW'(1);

            case (state_q)
                IDLE: begin
                    if (shoot_edge) begin
                        state_q        <= PLAY;
                        hold_q         <= '0;
                        run_q          <= 1'b1;
                        level_load_q   <= 1'b1;
                        player_reset_q <= 1'b1;
                    end
                end
                PLAY: begin
                    // Priority is hit, then landed, then cleared.
                    if (bus.hit_i) begin
                        hold_q <= '0;
                        run_q  <= 1'b0;
                        if (lives_q != 2'd0) begin
                            state_q     <= HIT_PAUSE;
                            lives_q     <= lives_q - 2'd1;
                            flash_q     <= 1'b1;
                            flash_cnt_q <= '0;
                        end else begin
                            state_q <= GAME_OVER;
                        end
                    end else if (bus.landed_i) begin
                        state_q <= GAME_OVER;
                        hold_q  <= '0;
                        run_q   <= 1'b0;
                        lives_q <= 2'd0;
                    end else if (bus.cleared_i) begin
                        state_q <= (level_q >= MAX_LEVEL) ? GAME_WON : LEVEL_CLEAR;
                        hold_q  <= '0;
                        run_q   <= 1'b0;
                    end
                end
                HIT_PAUSE: begin
                    if (bus.tick_i) begin
                        flash_cnt_q <= flash_cnt_q + 3'd1;
                        if (flash_cnt_q == 3'd7) flash_q <= ~flash_q;
                    end
                    // Resume without reloading the formation.
                    if (held && shoot_edge) begin
                        state_q        <= PLAY;
                        hold_q         <= '0;
                        run_q          <= 1'b1;
                        flash_q        <= 1'b0;
                        player_reset_q <= 1'b1;
                    end
                end
                LEVEL_CLEAR: begin
                    if (held && shoot_edge) begin
                        state_q        <= PLAY;
                        hold_q         <= '0;
                        run_q          <= 1'b1;
                        level_q        <= next_level;
                        level_load_q   <= 1'b1;
                        player_reset_q <= 1'b1;
`ifdef GAME_SEQ_BONUS_LIFE_EN
                        if (!next_level[0] && lives_q < MAX_LIVES) lives_q <= lives_q + 2'd1;
`else
`endif
                    end
                end
                GAME_OVER, GAME_WON: begin
                    if (held && shoot_edge) begin
                        state_q <= IDLE;
                        hold_q  <= '0;
                        lives_q <= START_LIVES;
                        level_q <= 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= '0;
                    run_q   <= 1'b0;
                    flash_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.run_o          = run_q;
    assign bus.flash_o        = flash_q;
    assign bus.level_load_o   = level_load_q;
    assign bus.player_reset_o = player_reset_q;
    assign bus.lives_o        = lives_q;
    assign bus.level_o        = level_q;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with hold_frames_p=4 and max_level_p=3.
module tb_game_sequencer;
    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_PLAY  = 6'b000010;
    localparam logic [5:0] S_HIT   = 6'b000100;
    localparam logic [5:0] S_CLEAR = 6'b001000;
    localparam logic [5:0] S_OVER  = 6'b010000;
    localparam logic [5:0] S_WON   = 6'b100000;

    logic clk_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

    game_sequencer_if bus ();

    game_sequencer #(
        .max_level_p  (3),
        .start_lives_p(2),
        .max_lives_p  (3),
        .hold_frames_p(4)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    // One clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n frame ticks, one per cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_i = 1'b1;
            step();
        end
        bus.tick_i = 1'b0;
    endtask

    // Press: the edge is sampled at the next clock edge; release after one more cycle.
    task automatic press_start();
        bus.shoot_i = 1'b1;
        step();
    endtask

    task automatic release_btn();
        bus.shoot_i = 1'b0;
        step();
    endtask

    // Directed scenario sequence.
    initial begin
        reset_i       = 1'b1;
        bus.tick_i    = 1'b0;
        bus.shoot_i   = 1'b0;
        bus.hit_i     = 1'b0;
        bus.cleared_i = 1'b0;
        bus.landed_i  = 1'b0;
        step();
        step();
        reset_i = 1'b0;

        // Reset state.
        check("rst_state", bus.state_o, S_IDLE);
        check("rst_lives", bus.lives_o, 2);
        check("rst_level", bus.level_o, 1);
        check("rst_run", bus.run_o, 0);
        check("rst_flash", bus.flash_o, 0);
        check("rst_load", bus.level_load_o, 0);
        check("rst_preset", bus.player_reset_o, 0);

        // Events outside PLAY are ignored.
        bus.hit_i = 1'b1;
        step();
        bus.hit_i = 1'b0;
        check("idle_hit_state", bus.state_o, S_IDLE);
        check("idle_hit_lives", bus.lives_o, 2);

        // Start.
        press_start();
        check("start_state", bus.state_o, S_PLAY);
        check("start_load", bus.level_load_o, 1);
        check("start_preset", bus.player_reset_o, 1);
        check("start_run", bus.run_o, 1);
        check("start_lives", bus.lives_o, 2);
        check("start_level", bus.level_o, 1);
        release_btn();
        check("start_load_pulse", bus.level_load_o, 0);
        check("start_preset_pulse", bus.player_reset_o, 0);
        check("start_run_hold", bus.run_o, 1);

        // First hit: pause, flash, early shoot ignored.
        bus.hit_i = 1'b1;
        step();
        bus.hit_i = 1'b0;
        check("hit1_state", bus.state_o, S_HIT);
        check("hit1_lives", bus.lives_o, 1);
        check("hit1_run", bus.run_o, 0);
        check("hit1_flash", bus.flash_o, 1);
        ticks(2);
        press_start();
        check("hit1_early_shoot", bus.state_o, S_HIT);
        release_btn();
        ticks(5);
        check("hit1_flash_7", bus.flash_o, 1);
        ticks(1);
        check("hit1_flash_8", bus.flash_o, 0);
        press_start();
        check("hit1_resume_state", bus.state_o, S_PLAY);
        check("hit1_resume_preset", bus.player_reset_o, 1);
        check("hit1_resume_noload", bus.level_load_o, 0);
        check("hit1_resume_run", bus.run_o, 1);
        check("hit1_resume_flash", bus.flash_o, 0);
        release_btn();

        // Hit together with clear: hit wins.
        bus.hit_i     = 1'b1;
        bus.cleared_i = 1'b1;
        step();
        bus.hit_i     = 1'b0;
        bus.cleared_i = 1'b0;
        check("hit2_state", bus.state_o, S_HIT);
        check("hit2_lives", bus.lives_o, 0);
        check("hit2_level", bus.level_o, 1);
        ticks(4);
        press_start();
        check("hit2_resume", bus.state_o, S_PLAY);
        release_btn();

        // Third hit with no spare lives: game over, then back to IDLE.
        bus.hit_i = 1'b1;
        step();
        bus.hit_i = 1'b0;
        check("hit3_state", bus.state_o, S_OVER);
        check("hit3_lives", bus.lives_o, 0);
        check("hit3_run", bus.run_o, 0);
        ticks(4);
        press_start();
        check("over_exit_state", bus.state_o, S_IDLE);
        check("over_exit_lives", bus.lives_o, 2);
        check("over_exit_level", bus.level_o, 1);
        check("over_exit_noload", bus.level_load_o, 0);
        check("over_exit_nopreset", bus.player_reset_o, 0);
        release_btn();

        // Clear all three levels.
        press_start();
        release_btn();
        bus.cleared_i = 1'b1;
        step();
        bus.cleared_i = 1'b0;
        check("clr1_state", bus.state_o, S_CLEAR);
        check("clr1_run", bus.run_o, 0);
        check("clr1_level", bus.level_o, 1);
        ticks(4);
        press_start();
        check("lvl2_state", bus.state_o, S_PLAY);
        check("lvl2_level", bus.level_o, 2);
        check("lvl2_load", bus.level_load_o, 1);
        check("lvl2_preset", bus.player_reset_o, 1);
`ifdef GAME_SEQ_BONUS_LIFE_EN
        check("lvl2_lives", bus.lives_o, 3);
`else
        check("lvl2_lives", bus.lives_o, 2);
`endif
        release_btn();
        bus.cleared_i = 1'b1;
        step();
        bus.cleared_i = 1'b0;
        check("clr2_state", bus.state_o, S_CLEAR);
        ticks(4);
        press_start();
        check("lvl3_level", bus.level_o, 3);
        check("lvl3_load", bus.level_load_o, 1);
`ifdef GAME_SEQ_BONUS_LIFE_EN
        check("lvl3_lives", bus.lives_o, 3);
`else
        check("lvl3_lives", bus.lives_o, 2);
`endif
        release_btn();
        bus.cleared_i = 1'b1;
        step();
        bus.cleared_i = 1'b0;
        check("won_state", bus.state_o, S_WON);
        check("won_run", bus.run_o, 0);
        check("won_level", bus.level_o, 3);
        ticks(4);
        press_start();
        check("won_exit_state", bus.state_o, S_IDLE);
        check("won_exit_level", bus.level_o, 1);
        check("won_exit_lives", bus.lives_o, 2);
        release_btn();

        // Landed with shoot held throughout.
        press_start();
        release_btn();
        bus.landed_i = 1'b1;
        bus.shoot_i  = 1'b1;
        step();
        bus.landed_i = 1'b0;
        check("land_state", bus.state_o, S_OVER);
        check("land_lives", bus.lives_o, 0);
        check("land_run", bus.run_o, 0);
        ticks(6);
        step();
        step();
        check("land_held_button", bus.state_o, S_OVER);
        release_btn();
        check("land_released", bus.state_o, S_OVER);
        press_start();
        check("land_exit_state", bus.state_o, S_IDLE);
        check("land_exit_lives", bus.lives_o, 2);
        release_btn();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
